// File: rtl/ns_arbt_pkg.sv
// Shared arbiter types and helpers.
package ns_arbt_pkg;

    typedef enum logic {
        ARBT_IDLE   = 1'b0,
        ARBT_LOCKED = 1'b1
    } arbt_fsm_e;

    // A programmed weight of zero still lets the requester send one packet.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/ns_gnrl_wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
interface ns_gnrl_wrr_arbiter_if #(
    parameter int ARBT_NUM = 4,
    parameter int WEIGHT_W = 3
);
    localparam int ID_W = $clog2(ARBT_NUM);

    logic [ARBT_NUM-1:0]          req_vec;
    logic [ARBT_NUM-1:0]          req_last;
    logic [ARBT_NUM*WEIGHT_W-1:0] weight;
    logic                         arbt_ena;
    logic [ARBT_NUM-1:0]          grt_vec;
    logic [ID_W-1:0]              grt_id;
    logic                         grt_vld;
    logic                         lock;

    modport master (
        output req_vec, req_last, weight, arbt_ena,
        input  grt_vec, grt_id, grt_vld, lock
    );

    modport slave (
        input  req_vec, req_last, weight, arbt_ena,
        output grt_vec, grt_id, grt_vld, lock
    );
endinterface

// File: rtl/ns_gnrl_rr_pick.sv
// Circular first-one search starting at a given index; purely combinational.
module ns_gnrl_rr_pick #(
    parameter int NUM  = 4,
    parameter int ID_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]  req,
    input  logic [ID_W-1:0] start,
    output logic [NUM-1:0]  gnt,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        j     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NUM; k++) begin
            j = (int'(start) + k) % NUM;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/ns_gnrl_wrr_arbiter.sv
// Weighted round-robin arbiter with packet locking; grant is combinational from state and requests.
// state       | meaning
// ARBT_IDLE   | between packets, circular search from ptr_r picks the winner
// ARBT_LOCKED | multi-beat packet in progress, grant held by owner_r
module ns_gnrl_wrr_arbiter
    import ns_arbt_pkg::*;
#(
    parameter int ARBT_NUM = 4,
    parameter int WEIGHT_W = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    ns_gnrl_wrr_arbiter_if.slave arb
);

    localparam int ID_W = $clog2(ARBT_NUM);

    arbt_fsm_e             fsm_r;
    logic [ID_W-1:0]       ptr_r;
    logic [ID_W-1:0]       owner_r;
    logic [WEIGHT_W-1:0]   used_r;

    logic [ARBT_NUM-1:0]   pick_vec;
    logic [ID_W-1:0]       pick_id;
    logic [ARBT_NUM-1:0]   grt_vec;
    logic [ID_W-1:0]       grt_id;
    logic                  grt_vld;
    logic                  xfer;
    logic                  last_xfer;
    logic [WEIGHT_W:0]     n_cnt;
    logic                  rotate;
    logic [ID_W-1:0]       ptr_next;
    logic [WEIGHT_W-1:0]   weight_a [ARBT_NUM];
    logic [ARBT_NUM-1:0]   owner_oh;

    for (genvar i = 0; i < ARBT_NUM; i++) begin : g_weight
        assign weight_a[i] = arb.weight[i*WEIGHT_W +: WEIGHT_W];
    end

    ns_gnrl_rr_pick #(
        .NUM  (ARBT_NUM),
        .ID_W (ID_W)
    ) u_pick (
        .req   (arb.req_vec),
        .start (ptr_r),
        .gnt   (pick_vec),
        .idx   (pick_id)
    );

    always_comb begin
        grt_vec = pick_vec;
        grt_id  = pick_id;
        if (fsm_r == ARBT_LOCKED) begin
            grt_vec = '0;
            grt_id  = '0;
            if (arb.req_vec[owner_r]) begin
                grt_vec[owner_r] = 1'b1;
                grt_id           = owner_r;
            end
        end
    end

    assign grt_vld   = |grt_vec;
    assign xfer      = grt_vld & arb.arbt_ena;
    assign last_xfer = xfer & arb.req_last[grt_id];

    // On any transfer grt_id is the winner: pick result in IDLE, owner_r in LOCKED.
    assign n_cnt    = (grt_id == ptr_r) ? ({1'b0, used_r} + 1'b1) : (WEIGHT_W+1)'(1);
    assign rotate   = 32'(n_cnt) >= eff_weight(32'(weight_a[grt_id]));
    assign ptr_next = (grt_id == ID_W'(ARBT_NUM-1)) ? '0 : grt_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r   <= ARBT_IDLE;
            owner_r <= '0;
        end else begin
            case (fsm_r)
                ARBT_IDLE: begin
                    if (xfer && !arb.req_last[grt_id]) begin
                        fsm_r   <= ARBT_LOCKED;
                        owner_r <= grt_id;
                    end
                end
                ARBT_LOCKED: begin
                    if (last_xfer) fsm_r <= ARBT_IDLE;
                end
                default: fsm_r <= ARBT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r  <= '0;
            used_r <= '0;
        end else if (last_xfer) begin
            if (rotate) begin
                ptr_r  <= ptr_next;
                used_r <= '0;
            end else begin
                ptr_r  <= grt_id;
                used_r <= n_cnt[WEIGHT_W-1:0];
            end
        end
    end

    assign arb.grt_vec = grt_vec;
    assign arb.grt_id  = grt_id;
    assign arb.grt_vld = grt_vld;
    assign arb.lock    = (fsm_r == ARBT_LOCKED);

    assign owner_oh = {{(ARBT_NUM-1){1'b0}}, 1'b1} << owner_r;

    a_grt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grt_vec));
    a_locked_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (fsm_r == ARBT_LOCKED) |-> ((grt_vec & ~owner_oh) == '0));

endmodule

// File: tb/tb_ns_gnrl_wrr_arbiter.sv
// Directed bench for the weighted round-robin arbiter with hand-computed grant sequences.
module tb_ns_gnrl_wrr_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ns_gnrl_wrr_arbiter_if #(.ARBT_NUM(4), .WEIGHT_W(3)) arb_if ();

    ns_gnrl_wrr_arbiter #(.ARBT_NUM(4), .WEIGHT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        arb_if.req_vec  = '0;
        arb_if.req_last = '0;
        arb_if.arbt_ena = 1'b0;
        arb_if.weight   = {4{3'd1}};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (arb_if.grt_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_grt_vld: got %b expected 0", arb_if.grt_vld);
        end
        n_tests++;
        if (arb_if.grt_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_grt_id: got %0d expected 0", arb_if.grt_id);
        end
        n_tests++;
        if (arb_if.lock !== 1'b0 || arb_if.grt_vec !== 4'b0000) begin
            n_fail++; $display("FAIL reset_lock_vec: got lock=%b vec=%b expected 0/0000", arb_if.lock, arb_if.grt_vec);
        end
        // arbt_ena and req_last without any request must not move the pointer
        arb_if.arbt_ena = 1'b1;
        arb_if.req_last = 4'b1111;
        tick();
        n_tests++;
        if (dut.ptr_r !== 2'd0 || dut.used_r !== 3'd0 || arb_if.lock !== 1'b0) begin
            n_fail++; $display("FAIL gating_no_grant: got ptr=%0d used=%0d lock=%b expected 0/0/0", dut.ptr_r, dut.used_r, arb_if.lock);
        end
        // enter a packet, then reset in the middle of it
        arb_if.weight   = {4{3'd1}};
        arb_if.req_vec  = 4'b0010;
        arb_if.req_last = 4'b0000;
        tick();
        n_tests++;
        if (arb_if.lock !== 1'b1) begin
            n_fail++; $display("FAIL midpkt_lock_set: got %b expected 1", arb_if.lock);
        end
        rst_n = 1'b0;
        #1;
        tick();
        n_tests++;
        if (arb_if.lock !== 1'b0 || dut.ptr_r !== 2'd0 || dut.used_r !== 3'd0) begin
            n_fail++; $display("FAIL midpkt_reset: got lock=%b ptr=%0d used=%0d expected 0/0/0", arb_if.lock, dut.ptr_r, dut.used_r);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_plain_rr();
        int exp_id [5];
        exp_id = '{0, 1, 2, 3, 0};
        do_reset();
        arb_if.weight   = {4{3'd1}};
        arb_if.req_vec  = 4'b1111;
        arb_if.req_last = 4'b1111;
        arb_if.arbt_ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (arb_if.grt_id !== 2'(exp_id[i]) || arb_if.grt_vld !== 1'b1) begin
                n_fail++; $display("FAIL plain_rr[%0d]: got id=%0d vld=%b expected %0d/1", i, arb_if.grt_id, arb_if.grt_vld, exp_id[i]);
            end
            tick();
        end
    endtask

    task automatic test_weighted();
        int exp_id [10];
        exp_id = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};
        do_reset();
        arb_if.weight   = {3'd2, 3'd0, 3'd1, 3'd3};
        arb_if.req_vec  = 4'b1111;
        arb_if.req_last = 4'b1111;
        arb_if.arbt_ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if (arb_if.grt_id !== 2'(exp_id[i])) begin
                n_fail++; $display("FAIL weighted[%0d]: got id=%0d expected %0d", i, arb_if.grt_id, exp_id[i]);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        logic exp_lock [3];
        exp_lock = '{1'b0, 1'b1, 1'b1};
        do_reset();
        arb_if.weight   = {4{3'd1}};
        arb_if.req_vec  = 4'b0011;
        arb_if.req_last = 4'b0010;
        arb_if.arbt_ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (arb_if.grt_id !== 2'd0 || arb_if.lock !== exp_lock[i]) begin
                n_fail++; $display("FAIL lock_beat%0d: got id=%0d lock=%b expected 0/%b", i + 1, arb_if.grt_id, arb_if.lock, exp_lock[i]);
            end
            tick();
        end
        // owner stalls: requester 1 must stay blocked
        arb_if.req_vec = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (arb_if.grt_vld !== 1'b0 || arb_if.grt_vec !== 4'b0000 || arb_if.lock !== 1'b1) begin
                n_fail++; $display("FAIL lock_stall%0d: got vld=%b vec=%b lock=%b expected 0/0000/1", i, arb_if.grt_vld, arb_if.grt_vec, arb_if.lock);
            end
            tick();
        end
        arb_if.req_vec  = 4'b0011;
        arb_if.req_last = 4'b0011;
        #1;
        n_tests++;
        if (arb_if.grt_id !== 2'd0 || arb_if.lock !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat4: got id=%0d lock=%b expected 0/1", arb_if.grt_id, arb_if.lock);
        end
        tick();
        n_tests++;
        if (arb_if.grt_id !== 2'd1 || arb_if.lock !== 1'b0) begin
            n_fail++; $display("FAIL lock_release: got id=%0d lock=%b expected 1/0", arb_if.grt_id, arb_if.lock);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        arb_if.weight   = {4{3'd1}};
        arb_if.req_vec  = 4'b0110;
        arb_if.req_last = 4'b0110;
        arb_if.arbt_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (arb_if.grt_id !== 2'd1 || dut.ptr_r !== 2'd0 || dut.used_r !== 3'd0) begin
                n_fail++; $display("FAIL bp_hold%0d: got id=%0d ptr=%0d used=%0d expected 1/0/0", i, arb_if.grt_id, dut.ptr_r, dut.used_r);
            end
            tick();
        end
        arb_if.arbt_ena = 1'b1;
        #1;
        n_tests++;
        if (arb_if.grt_id !== 2'd1) begin
            n_fail++; $display("FAIL bp_accept: got id=%0d expected 1", arb_if.grt_id);
        end
        tick();
        n_tests++;
        if (arb_if.grt_id !== 2'd2 || dut.ptr_r !== 2'd2) begin
            n_fail++; $display("FAIL bp_next: got id=%0d ptr=%0d expected 2/2", arb_if.grt_id, dut.ptr_r);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        arb_if.weight   = {4{3'd1}};
        arb_if.req_vec  = 4'b1111;
        arb_if.req_last = 4'b1111;
        arb_if.arbt_ena = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (dut.ptr_r !== 2'd3) begin
            n_fail++; $display("FAIL wrap_ptr: got %0d expected 3", dut.ptr_r);
        end
        arb_if.req_vec = 4'b0011;
        #1;
        n_tests++;
        if (arb_if.grt_id !== 2'd0) begin
            n_fail++; $display("FAIL wrap_skip: got id=%0d expected 0", arb_if.grt_id);
        end

        // lower weight of requester 0 mid-turn
        do_reset();
        arb_if.weight   = {3'd1, 3'd1, 3'd1, 3'd3};
        arb_if.req_vec  = 4'b0001;
        arb_if.req_last = 4'b0001;
        arb_if.arbt_ena = 1'b1;
        tick();
        n_tests++;
        if (dut.ptr_r !== 2'd0 || dut.used_r !== 3'd1) begin
            n_fail++; $display("FAIL wchg_credit: got ptr=%0d used=%0d expected 0/1", dut.ptr_r, dut.used_r);
        end
        arb_if.weight = {3'd1, 3'd1, 3'd1, 3'd1};
        tick();
        arb_if.req_vec = 4'b0011;
        #1;
        n_tests++;
        if (arb_if.grt_id !== 2'd1 || dut.used_r !== 3'd0) begin
            n_fail++; $display("FAIL wchg_rotate: got id=%0d used=%0d expected 1/0", arb_if.grt_id, dut.used_r);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_plain_rr();
        test_weighted();
        test_lock();
        test_backpressure();
        test_wrap_skip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
